dmem_req_ctrl: RTL and testbench

DMEM_REQ_CTRL -- requirements
Module: dmem_req_ctrl

---
 rtl/dmem_pkg.sv | 18 +
 rtl/dmem_timeout.sv | 37 +++
 rtl/dmem_req_ctrl.sv | 165 ++++++++++++++++
 tb/tb_dmem_req_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory request controller: FSM encoding,
// default timeout and a saturating increment helper.
package dmem_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    localparam int TIMEOUT_DEFAULT = 64;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/dmem_timeout.sv
// WAIT-state watchdog: counts enabled cycles since the last clear and flags
// when TIMEOUT cycles have been spent.
module dmem_timeout
    import dmem_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The count equals k-1 in the k-th WAIT cycle, so this fires in WAIT cycle TIMEOUT.
    assign expired = (cnt_q == 16'(TIMEOUT - 1));

endmodule

// File: rtl/dmem_req_ctrl.sv
// Pipeline-to-mem_system request controller (IDLE/ISSUE/WAIT/RESP).
// Optional access/hit statistics counters enabled by defining DMEM_STATS_EN.
module dmem_req_ctrl
    import dmem_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic        rsp_hit,
    output logic        busy,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_rd,
    output logic        mem_wr,
    input  logic [15:0] mem_data_out,
    input  logic        mem_done,
    input  logic        mem_stall,
    input  logic        mem_cache_hit,
    input  logic        mem_err
`ifdef DMEM_STATS_EN
    ,
    output logic [15:0] acc_cnt,
    output logic [15:0] hit_cnt
`endif
);

    state_e      state_q, state_d;
    logic        wr_q, wr_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        hit_q, hit_d;
    logic        to_clear, to_en, to_expired;
    logic        stall_unused;

    assign stall_unused = mem_stall;

    dmem_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (to_clear),
        .enable  (to_en),
        .expired (to_expired)
    );

    // Response registers change only on the transition into RESP, so they hold between responses.
    always_comb begin
        state_d   = state_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        hit_d     = hit_q;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        rsp_valid = 1'b0;
        to_clear  = 1'b0;
        to_en     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    wr_d    = req_wr;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    if (req_addr[0]) begin
                        err_d   = 1'b1;
                        hit_d   = 1'b0;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                mem_rd   = ~wr_q;
                mem_wr   = wr_q;
                to_clear = 1'b1;
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                to_en = 1'b1;
                if (mem_done) begin
                    if (!wr_q) begin
                        rdata_d = mem_data_out;
                    end
                    hit_d   = mem_cache_hit;
                    err_d   = mem_err;
                    state_d = S_RESP;
                end else if (to_expired) begin
                    err_d   = 1'b1;
                    hit_d   = 1'b0;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            hit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            hit_q   <= hit_d;
        end
    end

    // Gating with rst keeps req_ready low for the whole reset interval.
    assign req_ready = (state_q == S_IDLE) & rst;
    assign busy      = (state_q != S_IDLE);
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign rsp_hit   = hit_q;

`ifdef DMEM_STATS_EN
    logic        done_resp;
    logic [15:0] acc_q, hitc_q;

    assign done_resp = (state_q == S_WAIT) & mem_done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q  <= '0;
            hitc_q <= '0;
        end else if (done_resp) begin
            acc_q <= sat_inc(acc_q);
            if (mem_cache_hit) begin
                hitc_q <= sat_inc(hitc_q);
            end
        end
    end

    assign acc_cnt = acc_q;
    assign hit_cnt = hitc_q;
`endif

endmodule

// File: tb/tb_dmem_req_ctrl.sv
// Self-checking bench for dmem_req_ctrl: vector table, random transactions
// against a response model, reset-in-WAIT and statistics sequences.
module tb_dmem_req_ctrl;

    localparam int TMO = 8;

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] mdata;
        int          lat;    // WAIT cycle (1-based) carrying mem_done; 0 = never
        logic        hit;
        logic        merr;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_wr;
    logic [15:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err, rsp_hit, busy;
    logic [15:0] rsp_rdata, mem_addr, mem_wdata, mem_data_out;
    logic        mem_rd, mem_wr, mem_done, mem_stall, mem_cache_hit, mem_err;
`ifdef DMEM_STATS_EN
    logic [15:0] acc_cnt, hit_cnt;
`endif

    int          errors = 0;
    int          checks = 0;
    logic [15:0] m_rdata = '0;
    logic        m_err = 1'b0;
    logic        m_hit = 1'b0;
    logic [15:0] m_acc = '0;
    logic [15:0] m_hits = '0;
    vec_t        tbl[8];

    dmem_req_ctrl #(.TIMEOUT(TMO)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_wr        (req_wr),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_rdata     (rsp_rdata),
        .rsp_err       (rsp_err),
        .rsp_hit       (rsp_hit),
        .busy          (busy),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rd        (mem_rd),
        .mem_wr        (mem_wr),
        .mem_data_out  (mem_data_out),
        .mem_done      (mem_done),
        .mem_stall     (mem_stall),
        .mem_cache_hit (mem_cache_hit),
        .mem_err       (mem_err)
`ifdef DMEM_STATS_EN
        ,
        .acc_cnt       (acc_cnt),
        .hit_cnt       (hit_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, req_ready, 0);
        chk({tag, "_rsp"}, {rsp_valid, rsp_err, rsp_hit, busy, mem_rd, mem_wr}, 0);
        chk({tag, "_rdata"}, rsp_rdata, 0);
        chk({tag, "_maddr"}, mem_addr, 0);
        chk({tag, "_mwdata"}, mem_wdata, 0);
    endtask

    // Applies one request from an IDLE negedge and scripts the memory side.
    task automatic run_txn(input vec_t v);
        logic        mis, to;
        int          exp_lat, got_c, nrd, nwr;
        logic        bad;
        logic [15:0] e_rdata;
        logic        e_err, e_hit;
        mis     = v.addr[0];
        to      = !mis && (v.lat < 1 || v.lat > TMO);
        exp_lat = mis ? 1 : (to ? TMO + 2 : v.lat + 2);
        if (mis || to) begin
            e_err = 1'b1; e_hit = 1'b0; e_rdata = m_rdata;
        end else begin
            e_err = v.merr; e_hit = v.hit; e_rdata = v.wr ? m_rdata : v.mdata;
            if (m_acc != 16'hFFFF) m_acc++;
            if (v.hit && m_hits != 16'hFFFF) m_hits++;
        end
        chk("ready_idle", req_ready, 1);
        req_valid = 1'b1; req_wr = v.wr; req_addr = v.addr; req_wdata = v.wdata;
        mem_data_out = v.mdata; mem_cache_hit = v.hit; mem_err = v.merr;
        mem_done = 1'($urandom % 2);
        mem_stall = 1'($urandom % 2);
        got_c = 0; nrd = 0; nwr = 0; bad = 1'b0;
        for (int c = 1; c <= 40 && got_c == 0; c++) begin
            @(negedge clk);
            req_valid = 1'b0; req_wr = 1'($urandom); req_addr = 16'($urandom); req_wdata = 16'($urandom);
            nrd += int'(mem_rd);
            nwr += int'(mem_wr);
            if (mem_rd && mem_wr) bad = 1'b1;
            if (busy && (mem_addr !== v.addr || mem_wdata !== v.wdata)) bad = 1'b1;
            if (rsp_valid) begin
                got_c = c;
                chk("rsp_err", rsp_err, e_err);
                chk("rsp_hit", rsp_hit, e_hit);
                chk("rsp_rdata", rsp_rdata, e_rdata);
            end
            mem_done  = (c == 1) ? 1'($urandom % 2) : (!mis && (c - 1) == v.lat);
            mem_stall = 1'($urandom % 2);
        end
        chk("rsp_latency", got_c, exp_lat);
        chk("rd_pulses", nrd, (!mis && !v.wr) ? 1 : 0);
        chk("wr_pulses", nwr, (!mis && v.wr) ? 1 : 0);
        chk("mem_if_stable", bad, 0);
        @(negedge clk);
        chk("rsp_one_cycle", {rsp_valid, busy, req_ready}, 3'b001);
        chk("hold_rdata", rsp_rdata, e_rdata);
        chk("hold_flags", {rsp_err, rsp_hit}, {e_err, e_hit});
`ifdef DMEM_STATS_EN
        chk("acc_cnt", acc_cnt, m_acc);
        chk("hit_cnt", hit_cnt, m_hits);
`endif
        m_rdata = e_rdata; m_err = e_err; m_hit = e_hit;
    endtask

    initial begin
        vec_t rv;
        logic stale;
        tbl[0] = '{1'b0, 16'h0010, 16'h0000, 16'hBEEF, 2, 1'b1, 1'b0};
        tbl[1] = '{1'b1, 16'h0A40, 16'h1234, 16'h5555, 3, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 16'h0003, 16'h0000, 16'h7777, 1, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 16'h0020, 16'h0000, 16'h1111, 0, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 16'h0022, 16'h0000, 16'h2222, TMO, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 16'h0024, 16'h0000, 16'h3333, TMO + 1, 1'b1, 1'b0};
        tbl[6] = '{1'b0, 16'h0030, 16'h0000, 16'hCAFE, 1, 1'b0, 1'b1};
        tbl[7] = '{1'b1, 16'h0FFF, 16'hABCD, 16'h4444, 2, 1'b1, 1'b0};

        rst = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
        mem_data_out = '0; mem_done = 1'b0; mem_stall = 1'b0; mem_cache_hit = 1'b0; mem_err = 1'b0;
        #3;
        chk_all_zero("reset");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("ready_after_reset", req_ready, 1);

        foreach (tbl[i]) run_txn(tbl[i]);

        for (int i = 0; i < 40; i++) begin
            rv.wr    = 1'($urandom % 2);
            rv.addr  = 16'($urandom);
            if ($urandom % 4 != 0) rv.addr[0] = 1'b0;
            rv.wdata = 16'($urandom);
            rv.mdata = 16'($urandom);
            rv.lat   = int'($urandom_range(0, TMO + 2));
            rv.hit   = 1'($urandom % 2);
            rv.merr  = ($urandom % 5 == 0);
            run_txn(rv);
        end

        // Reset while the controller sits in WAIT.
        req_valid = 1'b1; req_wr = 1'b0; req_addr = 16'h0100; req_wdata = 16'h0; mem_done = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("busy_in_wait", busy, 1);
        #2 rst = 1'b0;
        #1;
        chk_all_zero("reset_wait");
`ifdef DMEM_STATS_EN
        chk("reset_stats", {acc_cnt, hit_cnt}, 0);
`endif
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("ready_after_wait_reset", req_ready, 1);
        stale = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (rsp_valid || busy) stale = 1'b1;
        end
        chk("no_stale_rsp", stale, 0);
        m_rdata = '0; m_err = 1'b0; m_hit = 1'b0; m_acc = '0; m_hits = '0;

        // Three hits and one miss.
        for (int i = 0; i < 4; i++) begin
            rv = '{1'b0, 16'(16'h0200 + 2 * i), 16'h0, 16'(16'h9000 + i), i + 1, (i != 2), 1'b0};
            run_txn(rv);
        end
`ifdef DMEM_STATS_EN
        chk("stats_acc_final", acc_cnt, 4);
        chk("stats_hit_final", hit_cnt, 3);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
